imm_ext_pipe: RTL and testbench
===============================

# imm_ext_pipe

Parametrised, registered immediate-extension unit for the pipelined CPU datapath. Accepts a raw immediate plus an extension opcode over a valid/ready handshake and computes the extended operand. The operand is one of zero, sign, high-half or branch target (PC-relative). Results are held in a 2-entry elastic buffer so the decode stage can stall or flush without losing or duplicating operands. The block replaces the combinational extender on the ID→EX path.

## Interface
- `IN_W`, 16: raw immediate width; must be less than `OUT_W`.
- `OUT_W`, 32: extended operand width; must be at least `IN_W + 2`.
- `TAG_W`, 5: width of the sideband tag carried with each operand, e.g. the destination register.
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous clear of all buffered entries.
- `in_valid`  in  1  the request on `in_*` is valid.
- `in_ready`  out  1  the block can accept a request this cycle.
- `in_imm`  in  IN_W  raw immediate.
- `in_op`  in  3  extension opcode.
- `in_pc`  in  OUT_W  PC of the instruction; used only by `EXT_BRTGT`.
- `in_tag`  in  TAG_W  sideband tag; passed through unchanged.
- `out_valid`  out  1  the head entry is valid.
- `out_ready`  in  1  the consumer takes the head entry this cycle.
- `out_data`  out  OUT_W  extended operand of the head entry.
- `out_tag`  out  TAG_W  tag of the head entry.
- `out_err`  out  1  the head entry was produced from an undefined opcode.

## Operation
- **Opcodes.**
  - 0 `EXT_UNSIGNED`: `{0, imm}`.
  - 1 `EXT_SIGNED`: `imm` sign-extended.
  - 2 `EXT_HIGHHALF`: `imm << (OUT_W-IN_W)`, low bits zero.
  - 3 `EXT_BRTGT`: `in_pc + 4 + (sext(imm) << 2)`, computed modulo 2^OUT_W; wrap-around is silent.
  - 4–7: undefined. Result is the zero-extended immediate and `err = 1`.
- **Compute point.** The result is computed combinationally at the accept edge and written into the buffer. Nothing is recomputed later.
- **Buffer.**
  - 2 slots, with 1-bit write pointer, 1-bit read pointer and a 2-bit count.
  - `in_ready = (count != 2)`. It depends only on registered state, never on `out_ready`.
  - `out_valid = (count != 0)`.
  - `out_data`, `out_tag` and `out_err` always show the slot at the read pointer. They are meaningful only while `out_valid` is high.
- **Push** = `in_valid & in_ready`. **Pop** = `out_valid & out_ready`.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - Push when full: cannot occur because `in_ready` is low. There is no bypass into a full buffer.
  - Pop when empty: ignored.
- **Flush.**
  - Count and both pointers go to 0. Slot contents are not cleared.
  - Flush overrides a same-cycle push and pop: the incoming request is dropped.
  - `in_ready` is 1 in the next cycle.
- **Reset.** Reset asserted mid-operation discards all entries immediately, i.e. asynchronously.

## Timing
- **Reset values.** `out_valid` 0, `in_ready` 1, `out_data` 0, `out_tag` 0, `out_err` 0. All slots and pointers are 0.
- **Latency.** A request accepted at edge N is visible on `out_*` with `out_valid = 1` after edge N.
  - With `out_ready` held high, throughput is 1 operand per cycle.
- **Stall.** With `out_ready` low, the buffer accepts 2 requests, then `in_ready` drops the cycle after the second push.
  - `in_ready` rises the cycle after the first pop.
- **Stability.** `out_*` stays stable while `out_valid & !out_ready`.
- **Critical path.** The critical path is the `EXT_BRTGT` adder into the slot write. No output is combinationally derived from any `in_*` signal.

## Configuration
- **Macro:** `IMM_EXT_BRTGT_EN`.
- **Defined:** opcode 3 computes the branch target as above, and `in_pc` is used.
- **Undefined:**
  - No adder is instantiated and `in_pc` is ignored.
  - Opcode 3 is treated as undefined: zero-extend with `err = 1`.

## Structure
- **Shared package `cpu_defs`:** `EXT_UNSIGNED`, `EXT_SIGNED`, `EXT_HIGHHALF`, `EXT_BRTGT` and the opcode width constant (3), alongside the existing datapath defines.
- **Sub-module `imm_ext_core`:** purely combinational; computes `(imm, op, pc)` → `(data, err)`. It contains the `IMM_EXT_BRTGT_EN` guard.
- **Top:** holds the buffer, pointers and handshake.

## Test plan
- **Reset.** Assert `reset_n` low mid-stream with 2 entries buffered → `out_valid` drops to 0 immediately, `in_ready` is 1, `out_data` is 0.
- **Modes.**
  - `imm = 16'h8001`, op 0/1/2 → `32'h00008001`, `32'hFFFF8001`, `32'h80010000`, each 1 cycle after accept.
  - op 5 → `32'h00008001` with `out_err = 1`.
- **Branch target** (macro defined): `pc = 32'h00003000`.
  - `imm = 16'hFFFF` → `32'h00003000`.
  - `pc = 32'hFFFFFFFC`, `imm = 0` → `32'h00000000` (wrap).
  - With the macro undefined, op 3 and `imm = 16'h0004` → `32'h00000004`, `err = 1`.
- **Backpressure.** Hold `out_ready = 0` and push A, B, C.
  - C is held off, with `in_ready = 0` after B.
  - Release → outputs A, B, C in order, with no loss or duplication.
- **Flush.** Issue a flush with 2 entries buffered while a push is offered in the same cycle.
  - Next cycle: `out_valid = 0`, `in_ready = 1`, and the offered request never appears.
- **Streaming.** 100 back-to-back pushes with `out_ready = 1` → 100 outputs in 100 consecutive cycles.
  - Tags 0..99 appear in order and `in_ready` never drops.

Source files
------------

// File: rtl/imm_ext_pipe_pkg.sv
// Shared CPU datapath definitions: immediate-extension opcodes and their width.
package cpu_defs;

    localparam int unsigned EXT_OP_W = 3;

    typedef enum logic [EXT_OP_W-1:0] {
        EXT_UNSIGNED = 3'd0,
        EXT_SIGNED   = 3'd1,
        EXT_HIGHHALF = 3'd2,
        EXT_BRTGT    = 3'd3
    } ext_op_e;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Request/operand handshake between decode and the immediate-extension pipe.
interface imm_ext_pipe_if
    import cpu_defs::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
);
    logic                in_valid;
    logic                in_ready;
    logic [IN_W-1:0]     in_imm;
    logic [EXT_OP_W-1:0] in_op;
    logic [OUT_W-1:0]    in_pc;
    logic [TAG_W-1:0]    in_tag;
    logic                out_valid;
    logic                out_ready;
    logic [OUT_W-1:0]    out_data;
    logic [TAG_W-1:0]    out_tag;
    logic                out_err;

    modport master (
        output in_valid, in_imm, in_op, in_pc, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_imm, in_op, in_pc, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_err
    );
endinterface

// File: rtl/imm_ext_pipe_core.sv
// Combinational immediate extender. Branch-target opcode is built only when
// IMM_EXT_BRTGT_EN is defined; otherwise opcode 3 is flagged as undefined.
module imm_ext_core
    import cpu_defs::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]     imm_i,
    input  logic [EXT_OP_W-1:0] op_i,
    input  logic [OUT_W-1:0]    pc_i,
    output logic [OUT_W-1:0]    data_o,
    output logic                err_o
);
    logic [OUT_W-1:0] zext;
    logic [OUT_W-1:0] sext;

    assign zext = {{(OUT_W-IN_W){1'b0}}, imm_i};
    assign sext = {{(OUT_W-IN_W){imm_i[IN_W-1]}}, imm_i};

`ifdef IMM_EXT_BRTGT_EN
    logic [OUT_W-1:0] brtgt;
    // Wraps modulo 2^OUT_W by construction.
    assign brtgt = pc_i + OUT_W'(4) + (sext << 2);
`else
    logic unused_pc;
    assign unused_pc = ^pc_i;
`endif

    always_comb begin
        data_o = zext;
        err_o  = 1'b0;
        case (op_i)
            EXT_UNSIGNED: data_o = zext;
            EXT_SIGNED:   data_o = sext;
            EXT_HIGHHALF: data_o = {imm_i, {(OUT_W-IN_W){1'b0}}};
`ifdef IMM_EXT_BRTGT_EN
            EXT_BRTGT:    data_o = brtgt;
`endif
            default:      err_o  = 1'b1;
        endcase
    end
endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender with a 2-entry elastic output buffer.
// Opcode 3 support follows IMM_EXT_BRTGT_EN (see imm_ext_core).
module imm_ext_pipe
    import cpu_defs::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          flush,
    imm_ext_pipe_if.slave bus
);
    logic [OUT_W-1:0] data_q [2];
    logic [TAG_W-1:0] tag_q  [2];
    logic             err_q  [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;

    logic [OUT_W-1:0] core_data;
    logic             core_err;
    logic             push, pop, wr_en;

    imm_ext_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .imm_i  (bus.in_imm),
        .op_i   (bus.in_op),
        .pc_i   (bus.in_pc),
        .data_o (core_data),
        .err_o  (core_err)
    );

    // Handshake outputs depend on registered state only.
    assign bus.in_ready  = (count_q != 2'd2);
    assign bus.out_valid = (count_q != 2'd0);
    assign bus.out_data  = data_q[rd_ptr_q];
    assign bus.out_tag   = tag_q[rd_ptr_q];
    assign bus.out_err   = err_q[rd_ptr_q];

    assign push  = bus.in_valid & bus.in_ready;
    assign pop   = bus.out_valid & bus.out_ready;
    assign wr_en = push & ~flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
                err_q[i]  <= 1'b0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en) begin
                data_q[wr_ptr_q] <= core_data;
                tag_q[wr_ptr_q]  <= bus.in_tag;
                err_q[wr_ptr_q]  <= core_err;
            end
        end
    end
endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed self-checking bench for imm_ext_pipe; honours IMM_EXT_BRTGT_EN.
module tb_imm_ext_pipe;
    localparam int unsigned IN_W  = 16;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned TAG_W = 7;

    logic clk;
    logic reset_n;
    logic flush;
    int   checks;
    int   errors;

    imm_ext_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)) bus ();

    imm_ext_pipe #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W),
        .TAG_W (TAG_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [15:0] imm, input logic [2:0] op,
                            input logic [31:0] pc, input logic [6:0] tag);
        bus.in_valid = 1'b1;
        bus.in_imm   = imm;
        bus.in_op    = op;
        bus.in_pc    = pc;
        bus.in_tag   = tag;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_one();
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
    endtask

    task automatic do_mode(input string name, input logic [15:0] imm, input logic [2:0] op,
                           input logic [31:0] pc, input logic [6:0] tag,
                           input logic [31:0] exp_data, input logic exp_err);
        push_one(imm, op, pc, tag);
        check({name, "_valid"}, 64'(bus.out_valid), 64'd1);
        check({name, "_data"},  64'(bus.out_data),  64'(exp_data));
        check({name, "_err"},   64'(bus.out_err),   64'(exp_err));
        check({name, "_tag"},   64'(bus.out_tag),   64'(tag));
        pop_one();
        check({name, "_drained"}, 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset_n       = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_imm    = '0;
        bus.in_op     = '0;
        bus.in_pc     = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();

        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_data",  64'(bus.out_data),  64'd0);
        check("rst_out_tag",   64'(bus.out_tag),   64'd0);
        check("rst_out_err",   64'(bus.out_err),   64'd0);

        do_mode("op_unsigned", 16'h8001, 3'd0, 32'h0, 7'd10, 32'h0000_8001, 1'b0);
        do_mode("op_signed",   16'h8001, 3'd1, 32'h0, 7'd11, 32'hFFFF_8001, 1'b0);
        do_mode("op_highhalf", 16'h8001, 3'd2, 32'h0, 7'd12, 32'h8001_0000, 1'b0);
        do_mode("op_undef5",   16'h8001, 3'd5, 32'h0, 7'd13, 32'h0000_8001, 1'b1);
        do_mode("op_undef7",   16'h1234, 3'd7, 32'h0, 7'd14, 32'h0000_1234, 1'b1);
`ifdef IMM_EXT_BRTGT_EN
        do_mode("brtgt_neg",   16'hFFFF, 3'd3, 32'h0000_3000, 7'd15, 32'h0000_3000, 1'b0);
        do_mode("brtgt_wrap",  16'h0000, 3'd3, 32'hFFFF_FFFC, 7'd16, 32'h0000_0000, 1'b0);
        do_mode("brtgt_pos",   16'h0010, 3'd3, 32'h0000_1000, 7'd17, 32'h0000_1044, 1'b0);
`else
        do_mode("brtgt_off",   16'h0004, 3'd3, 32'h0000_3000, 7'd15, 32'h0000_0004, 1'b1);
`endif

        // Backpressure: A, B fill the buffer, C must wait.
        push_one(16'h00A0, 3'd0, 32'h0, 7'd1);
        check("bp_ready_after_a", 64'(bus.in_ready), 64'd1);
        push_one(16'h00B0, 3'd0, 32'h0, 7'd2);
        check("bp_ready_after_b", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1;
        bus.in_imm   = 16'h00C0;
        bus.in_op    = 3'd0;
        bus.in_tag   = 7'd3;
        step();
        step();
        check("bp_c_held",     64'(bus.in_ready), 64'd0);
        check("bp_head_a_tag", 64'(bus.out_tag),  64'd1);
        check("bp_head_a_dat", 64'(bus.out_data), 64'h00A0);
        bus.out_ready = 1'b1;
        step();
        check("bp_head_b_tag", 64'(bus.out_tag),  64'd2);
        check("bp_head_b_dat", 64'(bus.out_data), 64'h00B0);
        check("bp_ready_rise", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        check("bp_head_c_tag", 64'(bus.out_tag),   64'd3);
        check("bp_head_c_dat", 64'(bus.out_data),  64'h00C0);
        check("bp_head_c_vld", 64'(bus.out_valid), 64'd1);
        step();
        bus.out_ready = 1'b0;
        check("bp_drained",    64'(bus.out_valid), 64'd0);

        // Flush with two entries buffered and a request offered.
        push_one(16'h00D0, 3'd0, 32'h0, 7'd4);
        push_one(16'h00E0, 3'd0, 32'h0, 7'd5);
        bus.in_valid = 1'b1;
        bus.in_tag   = 7'd6;
        flush        = 1'b1;
        step();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("fl_full_valid", 64'(bus.out_valid), 64'd0);
        check("fl_full_ready", 64'(bus.in_ready),  64'd1);
        step();
        step();
        check("fl_full_nodrop", 64'(bus.out_valid), 64'd0);

        // Flush overriding an accepted push and a pop in the same cycle.
        push_one(16'h00F0, 3'd0, 32'h0, 7'd7);
        bus.in_valid  = 1'b1;
        bus.in_tag    = 7'd8;
        bus.out_ready = 1'b1;
        flush         = 1'b1;
        step();
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        check("fl_push_valid", 64'(bus.out_valid), 64'd0);
        check("fl_push_ready", 64'(bus.in_ready),  64'd1);

        // Streaming: one operand per cycle with the consumer always ready.
        bus.out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            bus.in_valid = 1'b1;
            bus.in_imm   = 16'(i);
            bus.in_op    = 3'd0;
            bus.in_tag   = 7'(i);
            check("st_in_ready", 64'(bus.in_ready), 64'd1);
            step();
            check("st_out_valid", 64'(bus.out_valid), 64'd1);
            check("st_out_tag",   64'(bus.out_tag),   64'(i));
            check("st_out_data",  64'(bus.out_data),  64'(i));
        end
        bus.in_valid = 1'b0;
        step();
        bus.out_ready = 1'b0;
        check("st_drained", 64'(bus.out_valid), 64'd0);

        // Asynchronous reset with two entries buffered.
        push_one(16'h5555, 3'd1, 32'h0, 7'd20);
        push_one(16'h6666, 3'd1, 32'h0, 7'd21);
        check("ar_pre_valid", 64'(bus.out_valid), 64'd1);
        check("ar_pre_ready", 64'(bus.in_ready),  64'd0);
        #2;
        reset_n = 1'b0;
        #1;
        check("ar_out_valid", 64'(bus.out_valid), 64'd0);
        check("ar_in_ready",  64'(bus.in_ready),  64'd1);
        check("ar_out_data",  64'(bus.out_data),  64'd0);
        check("ar_out_tag",   64'(bus.out_tag),   64'd0);
        step();
        reset_n = 1'b1;
        step();
        check("ar_post_valid", 64'(bus.out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
